// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU and its decode/issue stage:
//     - ALU op_code constants (shared with alu)
//     - instruction opcode constants and the largest legal R-type funct
//     - decode_t        : decoded fields of one instruction word (no PC)
//     - issue_bundle_t  : decoded fields plus the PC tag
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int XLEN = 32;

    // ALU op_code values
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_AND  = 5'd1;
    localparam logic [4:0] ALU_OR   = 5'd2;
    localparam logic [4:0] ALU_NOR  = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_SLL  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_SEQ  = 5'd8;
    localparam logic [4:0] ALU_SNE  = 5'd9;
    localparam logic [4:0] ALU_SLT  = 5'd10;
    localparam logic [4:0] ALU_SGE  = 5'd11;
    localparam logic [4:0] ALU_SGT  = 5'd12;
    localparam logic [4:0] ALU_SLE  = 5'd13;
    localparam logic [4:0] ALU_SLTU = 5'd14;
    localparam logic [4:0] ALU_GTU  = 5'd15;
    localparam logic [4:0] ALU_SUB  = 5'd16;

    // Instruction opcodes (instr[31:26])
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_SEQI  = 6'h04;
    localparam logic [5:0] OPC_SNEI  = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_SLTIU = 6'h0B;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI  = 6'h0E;

    // R-type funct values 0x00..FUNCT_MAX map straight onto op_code
    localparam logic [5:0] FUNCT_MAX = 6'h10;

    typedef struct packed {
        logic [4:0]  op;
        logic        use_imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic        illegal;
    } decode_t;

    typedef struct packed {
        logic [4:0]      op;
        logic            use_imm;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      rd;
        logic [15:0]     imm;
        logic            illegal;
        logic [XLEN-1:0] pc;
    } issue_bundle_t;

endpackage

// File: rtl/alu_decode_lut.sv
// ---------------------------------------------------------------------------
// alu_decode_lut
//   Purely combinational decoder: 32-bit instruction word -> decode_t.
//   Ports:
//     instr  in  [31:0]  instruction word
//     dec    out decode_t decoded op/use_imm/rs/rt/rd/imm/illegal
//   Illegal words keep rs/rt/imm raw but force op=0, use_imm=0, rd=0 so
//   the ALU result is never written back.
// ---------------------------------------------------------------------------
module alu_decode_lut
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output decode_t     dec
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       imm_legal;
    logic [4:0] imm_op;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    always_comb begin
        imm_legal = 1'b1;
        imm_op    = ALU_ADD;
        case (opcode)
            OPC_ADDI:  imm_op = ALU_ADD;
            OPC_ANDI:  imm_op = ALU_AND;
            OPC_ORI:   imm_op = ALU_OR;
            OPC_XORI:  imm_op = ALU_XOR;
            OPC_SLTI:  imm_op = ALU_SLT;
            OPC_SLTIU: imm_op = ALU_SLTU;
            OPC_SEQI:  imm_op = ALU_SEQ;
            OPC_SNEI:  imm_op = ALU_SNE;
            default:   imm_legal = 1'b0;
        endcase
    end

    always_comb begin
        dec         = '0;
        dec.rs      = instr[25:21];
        dec.rt      = instr[20:16];
        dec.imm     = instr[15:0];
        dec.illegal = 1'b1;
        if (opcode == OPC_RTYPE) begin
            if (funct <= FUNCT_MAX) begin
                dec.illegal = 1'b0;
                dec.op      = funct[4:0];
                dec.rd      = instr[15:11];
            end
        end else if (imm_legal) begin
            // I-type writes back to rt
            dec.illegal = 1'b0;
            dec.use_imm = 1'b1;
            dec.op      = imm_op;
            dec.rd      = instr[20:16];
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//   Decode-and-issue stage in front of the combinational ALU. Decodes each
//   accepted instruction into an issue bundle held in a registered output
//   with a 2-entry skid buffer (main + skid), and counts illegal words.
//   Ports:
//     clk, rst_n                 clock, synchronous active-low reset
//     in_valid/in_ready          upstream handshake
//     in_instr, in_pc            instruction word and PC tag
//     out_valid/out_ready        downstream handshake
//     out_op, out_use_imm,
//     out_rs, out_rt, out_rd,
//     out_imm, out_illegal,
//     out_pc                     decoded bundle (from the main register)
//     illegal_count              saturating count of illegal words issued
//
//   Handshake: on either side a word moves on a rising edge where valid and
//   ready are both high. out_valid and the bundle only change after such a
//   transfer (or reset). in_ready depends only on rst_n and the skid flag,
//   so out_ready never reaches fetch combinationally, and out_valid is a
//   plain register.
// ---------------------------------------------------------------------------
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_instr,
    input  logic [WIDTH-1:0] in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_op,
    output logic             out_use_imm,
    output logic [4:0]       out_rs,
    output logic [4:0]       out_rt,
    output logic [4:0]       out_rd,
    output logic [15:0]      out_imm,
    output logic             out_illegal,
    output logic [WIDTH-1:0] out_pc,
    output logic [CNT_W-1:0] illegal_count
);

    decode_t          dec;
    decode_t          main_q;
    decode_t          skid_q;
    logic [WIDTH-1:0] main_pc;
    logic [WIDTH-1:0] skid_pc;
    logic             main_valid;
    logic             skid_valid;
    logic [CNT_W-1:0] cnt;
    logic             in_fire;
    logic             out_fire;

    alu_decode_lut u_decode (
        .instr (in_instr[31:0]),
        .dec   (dec)
    );

    assign in_ready = rst_n && !skid_valid;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = main_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_pc    <= '0;
            skid_pc    <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_fire) begin
            // in_ready is low whenever skid is full, so at most one source
            // refills main here and ordering is preserved.
            if (skid_valid) begin
                main_q     <= skid_q;
                main_pc    <= skid_pc;
                skid_valid <= 1'b0;
            end else if (in_fire) begin
                main_q  <= dec;
                main_pc <= in_pc;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (in_fire) begin
            if (!main_valid) begin
                main_q     <= dec;
                main_pc    <= in_pc;
                main_valid <= 1'b1;
            end else begin
                skid_q     <= dec;
                skid_pc    <= in_pc;
                skid_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (out_fire && main_q.illegal && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign out_valid     = main_valid;
    assign out_op        = main_q.op;
    assign out_use_imm   = main_q.use_imm;
    assign out_rs        = main_q.rs;
    assign out_rt        = main_q.rt;
    assign out_rd        = main_q.rd;
    assign out_imm       = main_q.imm;
    assign out_illegal   = main_q.illegal;
    assign out_pc        = main_pc;
    assign illegal_count = cnt;

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
//   Table-driven vectors plus hand-written sequences for stall, counter
//   saturation and mid-stream reset. A negedge monitor keeps an expected
//   queue filled on every upstream transfer and drained on every
//   downstream transfer.
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;
    import alu_pkg::*;

    localparam int WIDTH = 32;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_instr;
    logic [WIDTH-1:0] in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       out_op;
    logic             out_use_imm;
    logic [4:0]       out_rs;
    logic [4:0]       out_rt;
    logic [4:0]       out_rd;
    logic [15:0]      out_imm;
    logic             out_illegal;
    logic [WIDTH-1:0] out_pc;
    logic [CNT_W-1:0] illegal_count;

    alu_issue_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_op        (out_op),
        .out_use_imm   (out_use_imm),
        .out_rs        (out_rs),
        .out_rt        (out_rt),
        .out_rd        (out_rd),
        .out_imm       (out_imm),
        .out_illegal   (out_illegal),
        .out_pc        (out_pc),
        .illegal_count (illegal_count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic issue_bundle_t model(input logic [31:0] w, input logic [31:0] pc);
        issue_bundle_t b;
        logic [5:0]    opc;
        logic [5:0]    fn;
        opc       = w[31:26];
        fn        = w[5:0];
        b         = '0;
        b.rs      = w[25:21];
        b.rt      = w[20:16];
        b.imm     = w[15:0];
        b.pc      = pc;
        b.illegal = 1'b1;
        if (opc == 6'h00) begin
            if (fn < 6'h11) begin
                b.illegal = 1'b0;
                b.op      = fn[4:0];
                b.rd      = w[15:11];
            end
        end else begin
            b.illegal = 1'b0;
            b.use_imm = 1'b1;
            b.rd      = w[20:16];
            case (opc)
                6'h08:   b.op = 5'd0;
                6'h0C:   b.op = 5'd1;
                6'h0D:   b.op = 5'd2;
                6'h0E:   b.op = 5'd4;
                6'h0A:   b.op = 5'd10;
                6'h0B:   b.op = 5'd14;
                6'h04:   b.op = 5'd8;
                6'h05:   b.op = 5'd9;
                default: begin
                    b.illegal = 1'b1;
                    b.use_imm = 1'b0;
                    b.rd      = 5'd0;
                end
            endcase
        end
        return b;
    endfunction

    function automatic issue_bundle_t dut_bundle();
        issue_bundle_t b;
        b.op      = out_op;
        b.use_imm = out_use_imm;
        b.rs      = out_rs;
        b.rt      = out_rt;
        b.rd      = out_rd;
        b.imm     = out_imm;
        b.illegal = out_illegal;
        b.pc      = out_pc;
        return b;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [$bits(issue_bundle_t)-1:0] exp_q[$];
    logic [CNT_W-1:0]                 model_cnt = '0;
    issue_bundle_t                    prev_b;
    bit                               prev_stall = 1'b0;

    always @(negedge clk) begin
        issue_bundle_t cur;
        issue_bundle_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            cur = dut_bundle();
            if (prev_stall) begin
                check("stall_valid_hold", out_valid, 1'b1);
                check("stall_bundle_hold", cur, prev_b);
            end
            if (out_valid && out_ready) begin
                check("output_expected", exp_q.size() != 0, 1'b1);
                check("illegal_count_pre_drain", illegal_count, model_cnt);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("scoreboard_bundle", cur, e);
                    if (e.illegal && model_cnt != {CNT_W{1'b1}})
                        model_cnt = model_cnt + 1'b1;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_b     = cur;
            if (in_valid && in_ready)
                exp_q.push_back(model(in_instr, in_pc));
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_word(input logic [31:0] instr, input logic [31:0] pc);
        bit acc;
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        check("accept_within_bound", ok, 1'b1);
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (exp_q.size() == 0 && !out_valid) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("drain_within_bound", done, 1'b1);
    endtask

    function automatic logic [31:0] rand_word();
        logic [5:0]  opcs[10];
        logic [31:0] r;
        opcs = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0B, 6'h04, 6'h05, 6'h3F};
        r    = $urandom();
        return {opcs[$urandom_range(0, 9)], r[25:0]};
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] instr;
        logic [4:0]  op;
        logic        use_imm;
        logic [4:0]  rd;
        logic        illegal;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs[NV];

    initial begin
        issue_bundle_t exp_b;
        int            n_sat;

        vecs[0]  = '{32'h00221800, 5'd0,  1'b0, 5'd3,  1'b0}; // ADD r3,r1,r2
        vecs[1]  = '{32'h2025FFFF, 5'd0,  1'b1, 5'd5,  1'b0}; // ADDI r5,r1,-1
        vecs[2]  = '{32'hFC000000, 5'd0,  1'b0, 5'd0,  1'b1}; // opcode 0x3F
        vecs[3]  = '{32'h00853010, 5'd16, 1'b0, 5'd6,  1'b0}; // funct 0x10 SUB
        vecs[4]  = '{32'h00853011, 5'd0,  1'b0, 5'd0,  1'b1}; // funct 0x11
        vecs[5]  = '{32'h0085300F, 5'd15, 1'b0, 5'd6,  1'b0}; // funct 0x0F
        vecs[6]  = '{32'h30471234, 5'd1,  1'b1, 5'd7,  1'b0}; // ANDI
        vecs[7]  = '{32'h346800FF, 5'd2,  1'b1, 5'd8,  1'b0}; // ORI
        vecs[8]  = '{32'h381F8000, 5'd4,  1'b1, 5'd31, 1'b0}; // XORI
        vecs[9]  = '{32'h292A0001, 5'd10, 1'b1, 5'd10, 1'b0}; // SLTI
        vecs[10] = '{32'h2C227FFF, 5'd14, 1'b1, 5'd2,  1'b0}; // SLTIU
        vecs[11] = '{32'h10A60005, 5'd8,  1'b1, 5'd6,  1'b0}; // SEQI
        vecs[12] = '{32'h14C70006, 5'd9,  1'b1, 5'd7,  1'b0}; // SNEI
        vecs[13] = '{32'h08000010, 5'd0,  1'b0, 5'd0,  1'b1}; // opcode 0x02
        vecs[14] = '{32'h0022183F, 5'd0,  1'b0, 5'd0,  1'b1}; // funct 0x3F
        vecs[15] = '{32'h3C000000, 5'd0,  1'b0, 5'd0,  1'b1}; // opcode 0x0F

        // ---- reset ----
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_in_ready", in_ready, 1'b0);
        check("reset_illegal_count", illegal_count, 16'd0);
        check("reset_bundle", dut_bundle(), '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_release", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // ---- table: one word at a time, checked in cycle N+1 ----
        for (int i = 0; i < NV; i++) begin
            send_word(vecs[i].instr, 32'h1000 + 32'(i * 4));
            exp_b         = '0;
            exp_b.op      = vecs[i].op;
            exp_b.use_imm = vecs[i].use_imm;
            exp_b.rs      = vecs[i].instr[25:21];
            exp_b.rt      = vecs[i].instr[20:16];
            exp_b.rd      = vecs[i].rd;
            exp_b.imm     = vecs[i].instr[15:0];
            exp_b.illegal = vecs[i].illegal;
            exp_b.pc      = 32'h1000 + 32'(i * 4);
            check($sformatf("vec%0d_out_valid", i), out_valid, 1'b1);
            check($sformatf("vec%0d_bundle", i), dut_bundle(), exp_b);
            if (i == 2)
                check("illegal_count_before_drain", illegal_count, 16'd0);
            if (i == 3)
                check("illegal_count_after_drain", illegal_count, 16'd1);
        end
        wait_drain();
        check("illegal_count_after_table", illegal_count, 16'd5);

        // ---- 8-word stream with a 3-cycle stall ----
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send_word(rand_word(), 32'h2000 + 32'(i * 4));
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                check("stall_c0_in_ready", in_ready, 1'b1);
                @(negedge clk);
                check("stall_c1_in_ready", in_ready, 1'b0);
                @(negedge clk);
                check("stall_c2_in_ready", in_ready, 1'b0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                @(negedge clk);
                check("release_c0_in_ready", in_ready, 1'b0);
                @(negedge clk);
                check("release_c1_in_ready", in_ready, 1'b1);
            end
        join
        wait_drain();
        check("stream_queue_empty", exp_q.size(), 0);

        // ---- counter saturation ----
        n_sat = 32'hFFFE - int'(model_cnt);
        in_valid = 1'b1;
        in_instr = 32'hFC000000;
        for (int i = 0; i < n_sat; i++) begin
            in_pc = 32'(i);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_drain();
        check("illegal_count_fffe", illegal_count, 16'hFFFE);
        for (int i = 0; i < 3; i++)
            send_word(32'hFC000000 | 32'(i), 32'h3000 + 32'(i));
        wait_drain();
        check("illegal_count_saturated", illegal_count, 16'hFFFF);

        // ---- reset with both entries full ----
        out_ready = 1'b0;
        send_word(32'h00221800, 32'h4000);
        send_word(32'h2025FFFF, 32'h4004);
        @(negedge clk);
        check("full_out_valid", out_valid, 1'b1);
        check("full_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        model_cnt = '0;
        check("midreset_out_valid", out_valid, 1'b0);
        check("midreset_illegal_count", illegal_count, 16'd0);
        check("midreset_bundle", dut_bundle(), '0);
        check("midreset_in_ready", in_ready, 1'b0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("midreset_release_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        send_word(32'h0085300F, 32'h5000);
        exp_b = model(32'h0085300F, 32'h5000);
        check("post_reset_bundle", dut_bundle(), exp_b);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode-and-issue stage that sits directly upstream of the combinational `alu`. It accepts 32-bit instruction words from fetch over a valid/ready handshake and decodes each one into the ALU's `op_code` / `use_imm` / operand fields. Results go out through a registered, full-throughput output with a 2-entry skid buffer, so back-pressure from execute never creates a combinational path to fetch. Illegal encodings are flagged, neutralised, and counted.

## Interface
- `WIDTH`, 32: instruction and PC width.
- `CNT_W`, 16: width of the illegal-instruction counter.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: synchronous active-low reset.
- `in_valid` input 1: instruction word valid.
- `in_ready` output 1: stage can accept a word.
- `in_instr` input WIDTH: instruction word.
- `in_pc` input WIDTH: PC tag, passed through unchanged.
- `out_valid` output 1: decoded bundle valid.
- `out_ready` input 1: execute accepts the bundle.
- `out_op` output 5: ALU op_code.
- `out_use_imm` output 1: drives ALU `use_imm`.
- `out_rs`, `out_rt`, `out_rd` output 5 each: register indices.
- `out_imm` output 16: instr[15:0]. The ALU does its own sign or zero extension.
- `out_illegal` output 1: encoding not recognised.
- `out_pc` output WIDTH: PC tag.
- `illegal_count` output CNT_W: saturating count of illegal words issued.

## Operation
- Fields: opcode=instr[31:26], rs=instr[25:21], rt=instr[20:16], rd_r=instr[15:11], funct=instr[5:0].
- R-type (opcode 0x00):
  - funct 0x00–0x10 are legal. op = funct[4:0], use_imm=0, rd = rd_r.
  - funct 0x11–0x3F are illegal.
- I-type (use_imm=1, rd = rt, out_rt = rt):
  - 0x08 ADDI→0, 0x0C ANDI→1, 0x0D ORI→2, 0x0E XORI→4.
  - 0x0A SLTI→10, 0x0B SLTIU→14, 0x04 SEQI→8, 0x05 SNEI→9.
- All other opcodes are illegal.
- Illegal word: still issued in order, with out_illegal=1, out_op=0, out_use_imm=0, out_rd=0 so no write-back occurs. rs, rt, imm and pc are passed through raw.
- Handshake: a transfer happens on any cycle where valid && ready, on each side independently. Once out_valid is high, the output bundle holds stable until out_ready.
- Buffering: one main output register plus one skid register.
  - On an upstream transfer, a word loads into main if main is empty or being drained this cycle. Otherwise it loads into skid.
  - When main drains and skid is full, skid moves into main in the same cycle.
- in_ready = rst_n && !skid_valid, driven purely from registers and the reset input.
- illegal_count increments by 1 on each downstream transfer with out_illegal=1. It saturates at 2^CNT_W−1 and does not wrap.

## Timing
- Reset, on a clk edge with rst_n=0:
  - out_valid=0, skid_valid=0, illegal_count=0.
  - All bundle fields are 0.
  - in_ready=0 while rst_n=0, and 1 on the first cycle after release.
- Latency: a word accepted at edge N is presented with out_valid=1 after edge N, i.e. in cycle N+1.
- Throughput: 1 word/cycle sustained while out_ready=1.
- Stall: when out_ready drops, at most one further word is accepted, into skid. in_ready falls the cycle after skid fills.
- Simultaneous accept, drain and skid full: skid→main is legal. The new word cannot be accepted because in_ready=0, so ordering is preserved.
- Reset mid-stream: both entries are discarded and in-flight words are lost. Upstream must re-send.
- No combinational path from out_ready to in_ready, or from in_valid to out_valid.

## Structure
- Shared package `alu_pkg` holds:
  - ALU op_code constants (ADD=0, SUB=16, AND=1 … GTU=15), shared with `alu`.
  - Opcode constants (OPC_RTYPE, OPC_ADDI, …).
  - A packed struct `issue_bundle_t` with fields op, use_imm, rs, rt, rd, imm, illegal, pc.
- Sub-module `alu_decode_lut`: purely combinational, instr → `issue_bundle_t` minus pc. The top level holds the skid buffer, handshake, and counter.

## Test plan
- Reset, then send 0x00221800 (ADD r3,r1,r2) with out_ready=1. Expect in cycle N+1: out_op=0, use_imm=0, rs=1, rt=2, rd=3, illegal=0.
- Send 0x2025FFFF (ADDI r5,r1,-1). Expect out_op=0, use_imm=1, rd=5, imm=0xFFFF.
- Send 0xFC000000. Expect out_illegal=1, out_op=0, rd=0, and illegal_count 0→1 on the drain edge.
- Back-to-back stream of 8 words, with out_ready held low for 3 cycles mid-stream:
  - in_ready drops one cycle after skid fills.
  - No word is lost or duplicated, order is preserved, and the bundle stays stable while stalled.
- Preload illegal_count to 0xFFFE via a stream of illegal words, then send 3 more. Count stops at 0xFFFF.
- Assert rst_n=0 with both entries full. Next cycle: out_valid=0, illegal_count=0. After release, in_ready=1.
